// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and default widths for the cache arbiter
package arb_pkg;
  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbitration of I-cache and D-cache line requests onto one memory port
module cache_arbiter
  import arb_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);
  state_t            state;
  logic              last_grant;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_wdata;
  logic              req_write;
  logic              d_act;
  logic              grant_i;
  logic              grant_d;
  // last_grant=1 means D was granted last, so I wins the next tie
  always_comb begin
    d_act   = d_pmem_read | d_pmem_write;
    grant_i = i_pmem_read & (~d_act | last_grant);
    grant_d = d_act & ~grant_i;
  end
  // grant in IDLE latches the request; service ends on mem_resp
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_write  <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_i | grant_d) begin
        state      <= grant_i ? SERVE_I : SERVE_D;
        last_grant <= grant_d;
        req_addr   <= grant_i ? i_pmem_address : d_pmem_address;
        req_wdata  <= grant_i ? '0 : d_pmem_wdata;
        req_write  <= grant_d & d_pmem_write;
      end
    end else if (mem_resp) begin
      state <= IDLE;
    end
  end
  // memory side comes only from registered request state; resp is combinational on mem_resp
  always_comb begin
    mem_read     = (state != IDLE) & ~req_write;
    mem_write    = (state != IDLE) & req_write;
    mem_address  = req_addr;
    mem_wdata    = req_wdata;
    i_pmem_rdata = mem_rdata;
    d_pmem_rdata = mem_rdata;
    i_pmem_resp  = (state == SERVE_I) & mem_resp;
    d_pmem_resp  = (state == SERVE_D) & mem_resp;
  end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed and random checks of cache_arbiter against a transaction-level model
module tb_cache_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;
  logic          clk = 0;
  logic          rst = 1;
  logic          i_pmem_read = 0;
  logic [AW-1:0] i_pmem_address = '0;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read = 0;
  logic          d_pmem_write = 0;
  logic [AW-1:0] d_pmem_address = '0;
  logic [LW-1:0] d_pmem_wdata = '0;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_resp = 0;
  int checks = 0;
  int errors = 0;
  int            m_own = 0;
  bit            m_last_d = 1;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;
  bit            m_wr = 0;
  int            n_own;
  bit            n_last_d;
  logic [AW-1:0] n_addr;
  logic [LW-1:0] n_wdata;
  bit            n_wr;
  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction
  // One clock: compare outputs mid-cycle, then advance the model across the edge
  task automatic cycle();
    bit ir, dr, pick_d;
    @(negedge clk);
    chk("mem_read", mem_read, m_own != 0 && !m_wr);
    chk("mem_write", mem_write, m_own != 0 && m_wr);
    if (m_own != 0) begin
      chk("mem_address", mem_address, m_addr);
      if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
    end
    chk("i_resp", i_pmem_resp, m_own == 1 && mem_resp);
    chk("d_resp", d_pmem_resp, m_own == 2 && mem_resp);
    chk("i_rdata", i_pmem_rdata, mem_rdata);
    chk("d_rdata", d_pmem_rdata, mem_rdata);
    n_own = m_own; n_last_d = m_last_d; n_addr = m_addr; n_wdata = m_wdata; n_wr = m_wr;
    if (rst) begin
      n_own = 0; n_last_d = 1; n_addr = '0; n_wdata = '0; n_wr = 0;
    end else if (m_own == 0) begin
      ir = i_pmem_read;
      dr = d_pmem_read || d_pmem_write;
      if (ir || dr) begin
        pick_d = dr && !(ir && m_last_d);
        n_own = pick_d ? 2 : 1;
        n_last_d = pick_d;
        n_addr = pick_d ? d_pmem_address : i_pmem_address;
        n_wdata = d_pmem_wdata;
        n_wr = pick_d && d_pmem_write;
      end
    end else if (mem_resp) begin
      n_own = 0;
    end
    @(posedge clk);
    #1;
    m_own = n_own; m_last_d = n_last_d; m_addr = n_addr; m_wdata = n_wdata; m_wr = n_wr;
  endtask
  initial begin
    // reset
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    cycle();
    // I-only fill
    i_pmem_read = 1; i_pmem_address = 32'h0000_1000;
    cycle();
    i_pmem_read = 0; i_pmem_address = 32'h0000_2000;
    #1;
    chk("ifill_read", mem_read, 1'b1);
    chk("ifill_addr", mem_address, 32'h0000_1000);
    cycle();
    mem_resp = 1; mem_rdata = {32{8'hAA}};
    #1;
    chk("ifill_resp", i_pmem_resp, 1'b1);
    chk("ifill_rdata", i_pmem_rdata, {32{8'hAA}});
    cycle();
    mem_resp = 0;
    cycle();
    // tie after reset: I first, then D
    rst = 1;
    cycle();
    rst = 0;
    i_pmem_read = 1; i_pmem_address = 32'h0000_3000;
    d_pmem_read = 1; d_pmem_address = 32'h0000_4000;
    cycle();
    #1;
    chk("tie1_owner_i", mem_address, 32'h0000_3000);
    mem_resp = 1;
    cycle();
    mem_resp = 0;
    cycle();
    #1;
    chk("tie1_then_d", mem_address, 32'h0000_4000);
    mem_resp = 1;
    cycle();
    mem_resp = 0; i_pmem_read = 0; d_pmem_read = 0;
    cycle();
    // I served alone, then a new tie goes to D first, then I
    i_pmem_read = 1;
    cycle();
    i_pmem_read = 0; mem_resp = 1;
    cycle();
    mem_resp = 0; i_pmem_read = 1; d_pmem_read = 1;
    cycle();
    #1;
    chk("tie2_owner_d", mem_address, 32'h0000_4000);
    mem_resp = 1;
    cycle();
    mem_resp = 0;
    cycle();
    #1;
    chk("tie2_then_i", mem_address, 32'h0000_3000);
    mem_resp = 1;
    cycle();
    mem_resp = 0; i_pmem_read = 0; d_pmem_read = 0;
    cycle();
    // D writeback with address change mid-service
    d_pmem_write = 1; d_pmem_address = 32'h8000_0040; d_pmem_wdata = {8{32'h1234_5678}};
    cycle();
    d_pmem_write = 0;
    #1;
    chk("wb_write", mem_write, 1'b1);
    chk("wb_read", mem_read, 1'b0);
    chk("wb_wdata", mem_wdata, {8{32'h1234_5678}});
    cycle();
    d_pmem_address = 32'hFFFF_FFC0;
    #1;
    chk("wb_addr_held", mem_address, 32'h8000_0040);
    cycle();
    mem_resp = 1;
    #1;
    chk("wb_resp", d_pmem_resp, 1'b1);
    cycle();
    mem_resp = 0;
    cycle();
    cycle();
    // reset during SERVE_I, late mem_resp
    i_pmem_read = 1; i_pmem_address = 32'h0000_5000;
    cycle();
    i_pmem_read = 0;
    cycle();
    rst = 1;
    cycle();
    rst = 0;
    cycle();
    mem_resp = 1; mem_rdata = rnd_line();
    #1;
    chk("late_resp_i", i_pmem_resp, 1'b0);
    chk("late_resp_rd", mem_read, 1'b0);
    cycle();
    // stray mem_resp in IDLE
    cycle();
    cycle();
    mem_resp = 0;
    cycle();
    #1;
    chk("idle_after_stray", mem_read | mem_write, 1'b0);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      i_pmem_read = ($urandom_range(0, 2) == 0);
      d_pmem_read = ($urandom_range(0, 3) == 0);
      d_pmem_write = ($urandom_range(0, 3) == 0);
      i_pmem_address = $urandom();
      d_pmem_address = $urandom();
      d_pmem_wdata = rnd_line();
      mem_rdata = rnd_line();
      mem_resp = ($urandom_range(0, 2) == 0);
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
